// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_PREFIX_EXT      = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK      = 8'hF0;
   localparam int         PS2_TIMEOUT_DEFAULT = 150000;

   // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus falling-edge detect.
module ps2_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic data_s,
   output logic fall_pulse
);

   logic r_clk_meta;
   logic r_clk_sync;
   logic r_clk_prev;
   logic r_data_meta;
   logic r_data_sync;

   // Synchronizer chains; reset to 1 because an idle PS/2 bus floats high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_clk_meta  <= 1'b1;
         r_clk_sync  <= 1'b1;
         r_clk_prev  <= 1'b1;
         r_data_meta <= 1'b1;
         r_data_sync <= 1'b1;
      end else begin
         r_clk_meta  <= ps2_clk;
         r_clk_sync  <= r_clk_meta;
         r_clk_prev  <= r_clk_sync;
         r_data_meta <= ps2_data;
         r_data_sync <= r_data_meta;
      end
   end

   assign data_s     = r_data_sync;
   assign fall_pulse = r_clk_prev & ~r_clk_sync;

endmodule

// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard frame receiver with E0/F0 prefix folding and a one-deep event holding register.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx_controller
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       code_ready,
   output logic       code_valid,
   output logic [7:0] code,
   output logic       code_ext,
   output logic       code_break,
   output logic       frame_err,
   output logic       overflow
);

   localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   ps2_state_e    r_state;
   ps2_state_e    w_state_next;
   logic [7:0]    r_shift;
   logic [2:0]    r_bit_cnt;
   logic          r_parity;
   logic [TW-1:0] r_to_cnt;
   logic          r_ext_pend;
   logic          r_brk_pend;

   logic          r_code_valid;
   logic [7:0]    r_code;
   logic          r_code_ext;
   logic          r_code_break;
   logic          r_frame_err;
   logic          r_overflow;

   logic w_fall;
   logic w_data;
   logic w_frame_done;
   logic w_timeout;
   logic w_parity_ok;
   logic w_byte_ok;
   logic w_err;
   logic w_is_ext;
   logic w_is_brk;
   logic w_event;
   logic w_load;
   logic w_drop;

   ps2_sync_edge u_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .data_s     (w_data),
      .fall_pulse (w_fall)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; a timeout from any in-frame state abandons the frame.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_fall && !w_data) w_state_next = ST_DATA;
            else                   w_state_next = ST_IDLE;
         end
         ST_DATA: begin
            if (w_timeout)                         w_state_next = ST_IDLE;
            else if (w_fall && r_bit_cnt == 3'd7)  w_state_next = ST_PARITY;
            else                                   w_state_next = ST_DATA;
         end
         ST_PARITY: begin
            if (w_timeout)   w_state_next = ST_IDLE;
            else if (w_fall) w_state_next = ST_STOP;
            else             w_state_next = ST_PARITY;
         end
         ST_STOP: begin
            if (w_timeout || w_fall) w_state_next = ST_IDLE;
            else                     w_state_next = ST_STOP;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Frame outcome decode: error, prefix byte, or a complete key event.
   always_comb begin
      w_frame_done = (r_state == ST_STOP) && w_fall;
      w_timeout    = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == TO_LAST);
`ifdef PS2_PARITY_CHECK_EN
      w_parity_ok  = ps2_odd_parity_ok(r_shift, r_parity);
`else
      // Parity bit is captured but deliberately ignored in this build.
      w_parity_ok  = ps2_odd_parity_ok(r_shift, r_parity) | 1'b1;
`endif
      w_byte_ok    = w_frame_done && w_data && w_parity_ok;
      w_err        = w_timeout || (w_frame_done && !w_byte_ok);
      w_is_ext     = w_byte_ok && (r_shift == PS2_PREFIX_EXT);
      w_is_brk     = w_byte_ok && (r_shift == PS2_PREFIX_BRK);
      w_event      = w_byte_ok && !w_is_ext && !w_is_brk;
      w_load       = w_event && (!r_code_valid || code_ready);
      w_drop       = w_event && r_code_valid && !code_ready;
   end

   // Frame datapath: shift register, bit counter, parity capture, timeout and prefix flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift    <= 8'h00;
         r_bit_cnt  <= 3'd0;
         r_parity   <= 1'b0;
         r_to_cnt   <= '0;
         r_ext_pend <= 1'b0;
         r_brk_pend <= 1'b0;
      end else begin
         if (r_state == ST_IDLE || w_fall) r_to_cnt <= '0;
         else                              r_to_cnt <= r_to_cnt + 1'b1;

         if (r_state == ST_IDLE && w_fall && !w_data) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
         end else if (r_state == ST_DATA && w_fall) begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end

         if (r_state == ST_PARITY && w_fall) r_parity <= w_data;

         if (w_err || w_event) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
         end else begin
            if (w_is_ext) r_ext_pend <= 1'b1;
            if (w_is_brk) r_brk_pend <= 1'b1;
         end
      end
   end

   // Output holding register and status pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_code_valid <= 1'b0;
         r_code       <= 8'h00;
         r_code_ext   <= 1'b0;
         r_code_break <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_frame_err <= w_err;
         r_overflow  <= w_drop;
         if (w_load) begin
            r_code_valid <= 1'b1;
            r_code       <= r_shift;
            r_code_ext   <= r_ext_pend;
            r_code_break <= r_brk_pend;
         end else if (code_ready) begin
            r_code_valid <= 1'b0;
         end
      end
   end

   assign code_valid = r_code_valid;
   assign code       = r_code;
   assign code_ext   = r_code_ext;
   assign code_break = r_code_break;
   assign frame_err  = r_frame_err;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Self-checking bench for ps2_rx_controller: directed scenarios plus a randomized frame stream
// scored against a frame-level model of prefix folding and error handling.
module tb_ps2_rx_controller;

   localparam int TB_TO = 40;  // short timeout keeps the run small
   localparam int HALF  = 6;   // clk cycles per PS/2 clock half-period
   localparam int LAT   = 3;   // 2 sync flops + edge compare + output register

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       code_ready = 1'b1;
   logic       code_valid;
   logic [7:0] code;
   logic       code_ext;
   logic       code_break;
   logic       frame_err;
   logic       overflow;

   ps2_rx_controller #(.TIMEOUT_CYCLES(TB_TO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .code_ready (code_ready),
      .code_valid (code_valid),
      .code       (code),
      .code_ext   (code_ext),
      .code_break (code_break),
      .frame_err  (frame_err),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: accepted events as {ext, break, code}, pulse counts, latencies from the last PS/2 fall.
   logic [9:0] got_q[$];
   int   n_err = 0;
   int   n_ovf = 0;
   int   n_vcyc = 0;
   int   since = 0;
   int   lat_valid = -1;
   int   lat_err = -1;
   int   lat_ovf = -1;
   logic raw_prev = 1'b1;
   logic valid_prev = 1'b0;

   initial forever begin
      @(negedge clk);
      if (raw_prev && !ps2_clk) since = 0;
      else                      since = since + 1;
      raw_prev = ps2_clk;
      if (code_valid && !valid_prev) lat_valid = since;
      if (code_valid) n_vcyc++;
      if (frame_err) begin n_err++; lat_err = since; end
      if (overflow)  begin n_ovf++; lat_ovf = since; end
      if (code_valid && code_ready) got_q.push_back({code_ext, code_break, code});
      valid_prev = code_valid;
   end

   function automatic logic [31:0] q_at(input int i);
      if (i < got_q.size()) return {22'd0, got_q[i]};
      else                  return 32'hFFFF_FFFF;
   endfunction

   task automatic clr();
      got_q.delete();
      n_err = 0; n_ovf = 0; n_vcyc = 0;
      lat_valid = -1; lat_err = -1; lat_ovf = -1;
   endtask

   task automatic ps2_bit(input logic b);
      @(posedge clk); #2;
      ps2_data = b;
      repeat (HALF) @(posedge clk);
      #2 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #2 ps2_clk = 1'b1;
   endtask

   // Sends the first nbits of an 11-bit frame (start, 8 data LSB first, odd parity, stop).
   task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stopb, input int nbits);
      logic [10:0] bits;
      bits = {stopb, (~^b) ^ pflip, b, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
      repeat (4 * HALF) @(posedge clk);
      #2;
   endtask

   task automatic settle();
      repeat (10) @(posedge clk);
      #2;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_valid"}, {31'd0, code_valid}, 32'd0);
      check({pfx, "_code"},  {24'd0, code},       32'd0);
      check({pfx, "_ext"},   {31'd0, code_ext},   32'd0);
      check({pfx, "_brk"},   {31'd0, code_break}, 32'd0);
      check({pfx, "_ferr"},  {31'd0, frame_err},  32'd0);
      check({pfx, "_ovf"},   {31'd0, overflow},   32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [9:0] exp_q[$];
   int         exp_err;
   logic       m_ext;
   logic       m_brk;
   logic       par_en;

   initial begin
`ifdef PS2_PARITY_CHECK_EN
      par_en = 1'b1;
`else
      par_en = 1'b0;
`endif
      repeat (3) @(posedge clk); #2;
      check_reset_outputs("rst");
      reset_n = 1'b1;
      settle();
      clr();

      // Basic frame 0x1C with immediate acceptance.
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      check("basic_cnt", got_q.size(), 32'd1);
      check("basic_ev", q_at(0), 32'h01C);
      check("basic_lat", lat_valid, LAT);
      check("basic_vcyc", n_vcyc, 32'd1);
      check("basic_err", n_err, 32'd0);
      clr();

      // Extended break sequence folds into one event; flags clear afterwards.
      send_frame(8'hE0, 1'b0, 1'b1, 11);
      send_frame(8'hF0, 1'b0, 1'b1, 11);
      send_frame(8'h74, 1'b0, 1'b1, 11);
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      check("pfx_cnt", got_q.size(), 32'd2);
      check("pfx_ev0", q_at(0), 32'h374);
      check("pfx_ev1", q_at(1), 32'h01C);
      clr();

      // Wrong parity bit.
      send_frame(8'h1C, 1'b1, 1'b1, 11);
      check("par_cnt", got_q.size(), par_en ? 32'd0 : 32'd1);
      check("par_err", n_err, par_en ? 32'd1 : 32'd0);
      if (!par_en) check("par_ev", q_at(0), 32'h01C);
      clr();

      // Bad stop bit after an E0 prefix: error, and the prefix is forgotten.
      send_frame(8'hE0, 1'b0, 1'b1, 11);
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      check("stop_err", n_err, 32'd1);
      check("stop_lat", lat_err, LAT);
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      check("stop_cnt", got_q.size(), 32'd1);
      check("stop_ev", q_at(0), 32'h01C);
      clr();

      // Timeout: E0, then start plus 3 data bits and the bus left high.
      send_frame(8'hE0, 1'b0, 1'b1, 11);
      send_frame(8'h1C, 1'b0, 1'b1, 4);
      for (int k = 0; k < TB_TO + 60 && n_err == 0; k++) @(posedge clk);
      #2;
      check("to_err", n_err, 32'd1);
      check("to_lat", lat_err, TB_TO + LAT);
      settle();
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      check("to_cnt", got_q.size(), 32'd1);
      check("to_ev", q_at(0), 32'h01C);
      check("to_err2", n_err, 32'd1);
      clr();

      // Overflow: consumer stalled, second event dropped.
      code_ready = 1'b0;
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      send_frame(8'h32, 1'b0, 1'b1, 11);
      check("ovf_valid", {31'd0, code_valid}, 32'd1);
      check("ovf_code", {24'd0, code}, 32'h1C);
      check("ovf_cnt", n_ovf, 32'd1);
      check("ovf_lat", lat_ovf, LAT);
      code_ready = 1'b1;
      settle();
      check("ovf_drop", {31'd0, code_valid}, 32'd0);
      check("ovf_q", got_q.size(), 32'd1);
      check("ovf_ev", q_at(0), 32'h01C);
      clr();

      // Acceptance in the same cycle a new event lands: new event loads, no overflow.
      code_ready = 1'b0;
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      send_frame(8'h32, 1'b0, 1'b1, 10);
      @(posedge clk); #2;
      ps2_data = 1'b1;
      repeat (HALF) @(posedge clk);
      #2 ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      #2 code_ready = 1'b1;
      @(posedge clk);
      #2 code_ready = 1'b0;
      repeat (HALF - 3) @(posedge clk);
      #2 ps2_clk = 1'b1;
      settle();
      check("same_valid", {31'd0, code_valid}, 32'd1);
      check("same_code", {24'd0, code}, 32'h32);
      check("same_ovf", n_ovf, 32'd0);
      check("same_q0", q_at(0), 32'h01C);
      code_ready = 1'b1;
      settle();
      check("same_q1", q_at(1), 32'h032);
      clr();

      // Reset pulse after the 5th data bit.
      send_frame(8'hA5, 1'b0, 1'b1, 6);
      reset_n = 1'b0;
      repeat (3) @(posedge clk); #2;
      check_reset_outputs("mid");
      reset_n = 1'b1;
      settle();
      check("mid_err", n_err, 32'd0);
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      check("mid_cnt", got_q.size(), 32'd1);
      check("mid_ev", q_at(0), 32'h01C);
      check("mid_err2", n_err, 32'd0);
      clr();

      // Randomized frame stream against the frame-level model.
      exp_q.delete();
      exp_err = 0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      for (int i = 0; i < 40; i++) begin
         int         r;
         logic [7:0] b;
         logic       pflip;
         logic       stopb;
         r = int'($urandom_range(0, 9));
         if (r < 2)      b = 8'hE0;
         else if (r < 4) b = 8'hF0;
         else            b = 8'($urandom_range(0, 255));
         pflip = ($urandom_range(0, 7) == 0);
         stopb = ($urandom_range(0, 9) != 0);
         if (!stopb || (par_en && pflip)) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
         end else if (b == 8'hE0) begin
            m_ext = 1'b1;
         end else if (b == 8'hF0) begin
            m_brk = 1'b1;
         end else begin
            exp_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
         end
         send_frame(b, pflip, stopb, 11);
      end
      settle();
      check("rand_cnt", got_q.size(), exp_q.size());
      check("rand_err", n_err, exp_err);
      for (int j = 0; j < exp_q.size(); j++) check("rand_ev", q_at(j), {22'd0, exp_q[j]});

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
